multicycle_control: RTL and testbench

Multi-cycle main controller for the MIPS core. It replaces the single-cycle opcode decoder with a registered state machine that sequences one shared ALU and one unified instruction/data memory across several cycles per instruction. It sits between the instruction register (opcode source) and the multicycle datapath's mux selects and write enables. It stalls on a memory-ready handshake, flags illegal opcodes and pulses on every retired instruction.

---
 rtl/multicycle_control.sv | 161 ++++++++++++++++
 tb/tb_multicycle_control.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main controller: a single state register sequences the shared
// ALU and unified memory; all datapath controls are decoded from that state.
module multicycle_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       illegal_op,
    output logic       retire,
    output logic [3:0] state
);
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    state_t state_reg;
    state_t state_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = FETCH;
        case (state_reg)
            FETCH:    state_next = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = EXECUTE;
                    OP_BEQ:       state_next = BRANCH;
                    OP_ADDI:      state_next = ADDIEXEC;
                    OP_J:         state_next = JUMP;
                    default:      state_next = FETCH;
                endcase
            end
            // Only lw and sw reach MEMADR, so anything other than sw is a load.
            MEMADR:   state_next = (opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:    state_next = mem_ready ? MEMWB : MEMRD;
            MEMWR:    state_next = mem_ready ? FETCH : MEMWR;
            EXECUTE:  state_next = ALUWB;
            ADDIEXEC: state_next = ADDIWB;
            default:  state_next = FETCH;
        endcase
    end

    // Everything is forced low while rst is held so an aborted instruction writes nothing.
    always_comb begin
        IorD       = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        PCSrc      = 2'b00;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        illegal_op = 1'b0;
        retire     = 1'b0;
        state      = 4'd0;
        if (!rst) begin
            state = state_reg;
            case (state_reg)
                FETCH: begin
                    ALUSrcB = 2'b01;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                DECODE: begin
                    ALUSrcB = 2'b11;
                    case (opcode)
                        OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
                        default:                                       illegal_op = 1'b1;
                    endcase
                end
                MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                MEMRD: IorD = 1'b1;
                MEMWB: begin
                    MemtoReg = 1'b1;
                    RegWrite = 1'b1;
                    retire   = 1'b1;
                end
                MEMWR: begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                    retire   = mem_ready;
                end
                EXECUTE: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                ALUWB: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                    retire   = 1'b1;
                end
                BRANCH: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b01;
                    PCSrc   = 2'b01;
                    Branch  = 1'b1;
                    retire  = 1'b1;
                end
                ADDIEXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                ADDIWB: begin
                    RegWrite = 1'b1;
                    retire   = 1'b1;
                end
                JUMP: begin
                    PCSrc   = 2'b10;
                    PCWrite = 1'b1;
                    retire  = 1'b1;
                end
                default: state = state_reg;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected cycle traces are built
// from the instruction recipes and compared against the DUT on every cycle.
module tb_multicycle_control;
    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       IorD, ALUSrcA, IRWrite, PCWrite, Branch, MemWrite;
    logic       RegWrite, RegDst, MemtoReg, illegal_op, retire;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic [3:0] state;

    multicycle_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .IorD(IorD), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSrc(PCSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .Branch(Branch),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .illegal_op(illegal_op), .retire(retire),
        .state(state)
    );

    always #5 clk = ~clk;

    logic [20:0] act;
    assign act = {state, IorD, ALUSrcA, ALUSrcB, ALUOp, PCSrc, IRWrite, PCWrite,
                  Branch, MemWrite, RegWrite, RegDst, MemtoReg, illegal_op, retire};

    logic [20:0] exp_vec;
    logic        exp_valid = 1'b0;
    string       exp_name;
    int          compared = 0;
    int          mismatched = 0;
    int          step_idx = 0;
    int          retire_cnt = 0, rw_cnt = 0, mw_cnt = 0;

    always @(negedge clk) begin
        if (exp_valid) begin
            compared++;
            if (act !== exp_vec) begin
                mismatched++;
                $display("FAIL %s step %0d: got %h required %h", exp_name, step_idx, act, exp_vec);
            end
        end
        if (retire === 1'b1)   retire_cnt++;
        if (RegWrite === 1'b1) rw_cnt++;
        if (MemWrite === 1'b1) mw_cnt++;
    end

    function automatic logic [20:0] mk(input logic [3:0] st, input logic iord, input logic srca,
                                       input logic [1:0] srcb, input logic [1:0] aluop,
                                       input logic [1:0] pcsrc, input logic irw, input logic pcw,
                                       input logic br, input logic mw, input logic rw,
                                       input logic rd, input logic m2r, input logic ill,
                                       input logic ret);
        return {st, iord, srca, srcb, aluop, pcsrc, irw, pcw, br, mw, rw, rd, m2r, ill, ret};
    endfunction

    task automatic check_int(input string name, input int got, input int req);
        compared++;
        if (got != req) begin
            mismatched++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    // Runs one instruction; abort_after >= 0 cuts it short with a one-cycle reset.
    task automatic exec_instr(input string name, input logic [5:0] op, input int fstall,
                              input int mstall, input int exp_len, input int exp_ret,
                              input int exp_rw, input int exp_mw, input int abort_after);
        logic [20:0] qv[$];
        logic        qr[$];
        int          n, r0, w0, m0;
        for (int i = 0; i < fstall; i++) begin
            qv.push_back(mk(4'd0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0)); qr.push_back(1'b0);
        end
        qv.push_back(mk(4'd0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 0)); qr.push_back(1'b1);
        case (op)
            6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010:
                qv.push_back(mk(4'd1, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            default:
                qv.push_back(mk(4'd1, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        endcase
        qr.push_back(1'b1);
        case (op)
            6'b100011: begin
                qv.push_back(mk(4'd2, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0)); qr.push_back(1'b1);
                for (int i = 0; i < mstall; i++) begin
                    qv.push_back(mk(4'd3, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0)); qr.push_back(1'b0);
                end
                qv.push_back(mk(4'd3, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0)); qr.push_back(1'b1);
                qv.push_back(mk(4'd4, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 1)); qr.push_back(1'b1);
            end
            6'b101011: begin
                qv.push_back(mk(4'd2, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0)); qr.push_back(1'b1);
                for (int i = 0; i < mstall; i++) begin
                    qv.push_back(mk(4'd5, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0, 0)); qr.push_back(1'b0);
                end
                qv.push_back(mk(4'd5, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0, 1)); qr.push_back(1'b1);
            end
            6'b000000: begin
                qv.push_back(mk(4'd6, 0, 1, 2'b00, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0)); qr.push_back(1'b1);
                qv.push_back(mk(4'd7, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0, 1)); qr.push_back(1'b1);
            end
            6'b001000: begin
                qv.push_back(mk(4'd9, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0)); qr.push_back(1'b1);
                qv.push_back(mk(4'd10, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 1)); qr.push_back(1'b1);
            end
            6'b000100: begin
                qv.push_back(mk(4'd8, 0, 1, 2'b00, 2'b01, 2'b01, 0, 0, 1, 0, 0, 0, 0, 0, 1)); qr.push_back(1'b1);
            end
            6'b000010: begin
                qv.push_back(mk(4'd11, 0, 0, 2'b00, 2'b00, 2'b10, 0, 1, 0, 0, 0, 0, 0, 0, 1)); qr.push_back(1'b1);
            end
            default: ;
        endcase
        if (abort_after < 0) check_int({name, "_len"}, qv.size(), exp_len);
        r0 = retire_cnt; w0 = rw_cnt; m0 = mw_cnt;
        n = (abort_after >= 0) ? abort_after : qv.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rst = 1'b0; opcode = op; mem_ready = qr[i];
            exp_vec = qv[i]; exp_name = name; step_idx = i; exp_valid = 1'b1;
        end
        if (abort_after >= 0) begin
            @(posedge clk); #1;
            rst = 1'b1; mem_ready = 1'b1; exp_vec = '0; exp_name = {name, "_rst"}; step_idx = n;
        end
        @(negedge clk); #1;
        check_int({name, "_retire"}, retire_cnt - r0, exp_ret);
        check_int({name, "_regwrite"}, rw_cnt - w0, exp_rw);
        check_int({name, "_memwrite"}, mw_cnt - m0, exp_mw);
        $display("instr %s op=%b fstall=%0d mstall=%0d cycles=%0d", name, op, fstall, mstall, n);
    endtask

    initial begin
        rst = 1'b1; mem_ready = 1'b1; opcode = 6'b000000;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            exp_vec = '0; exp_name = "reset"; step_idx = i; exp_valid = 1'b1;
        end
        //          name        opcode     fs ms len ret rw mw abort
        exec_instr("lw",       6'b100011, 0, 0, 5,  1,  1, 0, -1);
        exec_instr("sw",       6'b101011, 0, 0, 4,  1,  0, 1, -1);
        exec_instr("rtype",    6'b000000, 0, 0, 4,  1,  1, 0, -1);
        exec_instr("addi",     6'b001000, 0, 0, 4,  1,  1, 0, -1);
        exec_instr("beq",      6'b000100, 0, 0, 3,  1,  0, 0, -1);
        exec_instr("j",        6'b000010, 0, 0, 3,  1,  0, 0, -1);
        exec_instr("illegal",  6'b111111, 0, 0, 2,  0,  0, 0, -1);
        exec_instr("sw_stall", 6'b101011, 0, 2, 6,  1,  0, 3, -1);
        exec_instr("lw_fstall",6'b100011, 1, 0, 6,  1,  1, 0, -1);
        exec_instr("lw_mstall",6'b100011, 2, 2, 9,  1,  1, 0, -1);
        exec_instr("illegal2", 6'b000001, 0, 0, 2,  0,  0, 0, -1);
        exec_instr("sw_abort", 6'b101011, 0, 1, 0,  0,  0, 1, 4);
        exec_instr("beq_after",6'b000100, 0, 0, 3,  1,  0, 0, -1);
        exec_valid_off();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    task automatic exec_valid_off();
        @(posedge clk); #1;
        exp_valid = 1'b0;
    endtask
endmodule
